axi_stream_egress_corrector: RTL and testbench
==============================================

# axi_stream_egress_corrector

Protocol corrector placed directly downstream of the AXI-Stream master decoupler on the egress path. It passes beats through combinationally and enforces a maximum packet length by forcing `tlast`. It then discards the oversize remainder of that packet, and can optionally terminate a stalled packet by injecting a closing beat. Its `axis_tlast_forced` output feeds the decoupler's input of the same name, so the decoupler's outstanding-packet tracking stays consistent with what leaves this block.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64: tdata width; must be a multiple of 8.
- AXIS_ID_WIDTH, 4: tid width.
- AXIS_DEST_WIDTH, 4: tdest width.
- MAX_PACKET_BEATS, 256: maximum beats per packet; must be ≥2.
- TIMEOUT_CYCLES, 1024: idle cycles mid-packet before injection; must be ≥1.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  reset, asynchronous and active-low.
- axis_s_tdata/tid/tdest/tkeep/tlast/tvalid  in  per params  ingress stream, from the decoupler's master side.
- axis_s_tready  out  1  ingress ready.
- axis_m_tdata/tid/tdest/tkeep/tlast/tvalid  out  per params  egress stream.
- axis_m_tready  in  1  egress ready.
- axis_tlast_forced  out  1  high on the ingress handshake that this block treats as end-of-packet without axis_s_tlast.
- oversize_error  out  1  single-cycle pulse, registered.
- timeout_error  out  1  single-cycle pulse, registered.

## Operation
States:
- IDLE: between packets.
- PKT: inside a packet.
- INJECT: driving the injected closing beat.
- DISCARD: dropping the remainder of a corrected packet.

Registers:
- beat_cnt: width $clog2(MAX_PACKET_BEATS+1); counts ingress beats of the current packet.
- idle_cnt: width $clog2(TIMEOUT_CYCLES+1).
- pkt_tid, pkt_tdest: captured on the first beat of each packet.

IDLE/PKT behaviour:
- Pass-through: m_tvalid=s_tvalid, s_tready=m_tready, and all data fields pass unchanged.
- On a handshake with s_tlast=1: go to IDLE, beat_cnt←0.
- On a handshake with s_tlast=0 and beat_cnt<MAX_PACKET_BEATS-1: go to PKT, beat_cnt+1.
- Forced end: on a handshake with s_tlast=0 and beat_cnt==MAX_PACKET_BEATS-1:
  - axis_m_tlast=1 and axis_tlast_forced=1 in that same cycle.
  - Go to DISCARD, beat_cnt←0.
  - oversize_error pulses the next cycle.
- If s_tlast=1 on beat number MAX_PACKET_BEATS, the packet is legal: no forcing, no error.

idle_cnt (PKT only):
- +1 each cycle s_tvalid=0.
- Cleared whenever s_tvalid=1 (downstream backpressure never counts as idle).
- Cleared on leaving PKT.

DISCARD:
- s_tready=1, m_tvalid=0.
- On a handshake with s_tlast=1: go to IDLE.
- axis_tlast_forced=0 throughout.
- No timeout applies here.

INJECT (macro only):
- s_tready=0, m_tvalid=1.
- Injected beat: tdata=0, tkeep=0, tlast=1, tid=pkt_tid, tdest=pkt_tdest.
- m_tvalid holds until m_tready; then go to DISCARD.
- axis_tlast_forced=0.

Reset:
- While aresetn=0, axis_m_tvalid=0 and axis_s_tready=0.
- All registers clear, state=IDLE, axis_tlast_forced=0, error pulses=0.
- A reset mid-packet abandons the packet. After reset, the next beat starts a fresh count.

## Timing
- Zero-cycle latency for data, valid and ready in IDLE/PKT; these are combinational paths.
- axis_tlast_forced is combinational, valid in the handshake cycle only.
- Error pulses are registered: exactly one cycle high, on the cycle after the triggering event.
- State updates on the clock edge after the handshake.

## Configuration
- Macro AXIS_TIMEOUT_INJECT_EN.
- Defined:
  - In PKT, when idle_cnt reaches TIMEOUT_CYCLES, go to INJECT on the next edge.
  - timeout_error pulses on INJECT entry.
- Undefined:
  - No idle_cnt, no INJECT state, timeout_error tied 0.
  - A stalled packet stays in PKT indefinitely.

## Test plan
- MAX_PACKET_BEATS=4, 3-beat packet with tlast on beat 3 → passes unchanged, axis_tlast_forced never high, no errors.
- MAX_PACKET_BEATS=4, 4-beat packet with tlast on beat 4 → legal, no forcing, oversize_error=0.
- MAX_PACKET_BEATS=4, 7-beat packet:
  - Beat 4 exits with tlast=1 and axis_tlast_forced=1.
  - oversize_error pulses one cycle later.
  - Beats 5–7 are accepted with s_tready=1 and never appear on m.
- Macro on, TIMEOUT_CYCLES=8, beats sent with tid=3, then s_tvalid=0 for 8 cycles:
  - Injected beat tlast=1, tkeep=0, tid=3; timeout_error pulses.
  - Later upstream beats are discarded through tlast.
- Downstream holds m_tready=0 for 20 cycles mid-packet with s_tvalid=1 (macro on, TIMEOUT_CYCLES=8) → no injection, beat_cnt unchanged.
- Assert aresetn=0 asynchronously mid-packet → m_tvalid=0 immediately; after release, a 2-beat packet passes with no forcing.

Source files
------------

// File: rtl/axi_stream_egress_corrector_if.sv
// axi_stream_egress_corrector_if: AXI-Stream bundle with master/slave views.
interface axi_stream_egress_corrector_if #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4
) ();
    logic [AXIS_BUS_WIDTH-1:0]   tdata;
    logic [AXIS_ID_WIDTH-1:0]    tid;
    logic [AXIS_DEST_WIDTH-1:0]  tdest;
    logic [AXIS_BUS_WIDTH/8-1:0] tkeep;
    logic                        tlast;
    logic                        tvalid;
    logic                        tready;
    modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axi_stream_egress_corrector.sv
// axi_stream_egress_corrector: pass-through that caps packet length by forcing tlast and dropping the rest.
// Define AXIS_TIMEOUT_INJECT_EN to close stalled packets with an injected empty tlast beat.
module axi_stream_egress_corrector #(
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_ID_WIDTH    = 4,
    parameter int AXIS_DEST_WIDTH  = 4,
    parameter int MAX_PACKET_BEATS = 256,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    axi_stream_egress_corrector_if.slave        axis_s,
    axi_stream_egress_corrector_if.master       axis_m,
    output logic                                axis_tlast_forced,
    output logic                                oversize_error,
    output logic                                timeout_error
);
    localparam int BW = $clog2(MAX_PACKET_BEATS + 1);
    typedef enum logic [1:0] {
        IDLE,
        PKT,
`ifdef AXIS_TIMEOUT_INJECT_EN
        INJECT,
`endif
        DISCARD
    } state_t;
    if (MAX_PACKET_BEATS < 2 || TIMEOUT_CYCLES < 1 || AXIS_BUS_WIDTH % 8 != 0) begin : g_param_check
        $error("axi_stream_egress_corrector: illegal parameters");
    end
    state_t                     r_state, w_next;
    logic [BW-1:0]              r_beat_cnt;
    logic [AXIS_ID_WIDTH-1:0]   r_pkt_tid;
    logic [AXIS_DEST_WIDTH-1:0] r_pkt_tdest;
    logic                       r_oversize_err;
    logic                       w_pass, w_inject, w_hs, w_force, w_timeout;
    assign w_pass = (r_state == IDLE) || (r_state == PKT);
`ifdef AXIS_TIMEOUT_INJECT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] r_idle_cnt;
    logic          r_timeout_err;
    assign w_inject      = r_state == INJECT;
    assign w_timeout     = (r_state == PKT) && (r_idle_cnt == IW'(TIMEOUT_CYCLES));
    assign timeout_error = r_timeout_err;
    // Backpressure with s_tvalid high never counts as idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_idle_cnt    <= (r_state == PKT && w_next == PKT && !axis_s.tvalid) ? r_idle_cnt + IW'(1) : '0;
            r_timeout_err <= (r_state != INJECT) && (w_next == INJECT);
        end
    end
`else
    assign w_inject      = 1'b0;
    assign w_timeout     = 1'b0;
    assign timeout_error = 1'b0;
`endif
    assign axis_s.tready     = aresetn & (w_pass ? axis_m.tready : (r_state == DISCARD));
    assign axis_m.tvalid     = aresetn & (w_pass ? axis_s.tvalid : w_inject);
    assign axis_m.tdata      = w_inject ? '0 : axis_s.tdata;
    assign axis_m.tkeep      = w_inject ? '0 : axis_s.tkeep;
    assign axis_m.tid        = w_inject ? r_pkt_tid : axis_s.tid;
    assign axis_m.tdest      = w_inject ? r_pkt_tdest : axis_s.tdest;
    assign w_hs              = axis_s.tvalid & axis_s.tready;
    assign w_force           = w_pass & w_hs & ~axis_s.tlast & (r_beat_cnt == BW'(MAX_PACKET_BEATS - 1));
    assign axis_m.tlast      = w_inject | axis_s.tlast | w_force;
    assign axis_tlast_forced = w_force;
    assign oversize_error    = r_oversize_err;
    always_comb begin
        w_next = r_state;
        if (w_pass) begin
            if (w_hs && axis_s.tlast) w_next = IDLE;
            else if (w_force) w_next = DISCARD;
`ifdef AXIS_TIMEOUT_INJECT_EN
            else if (w_timeout) w_next = INJECT;
`endif
            else if (w_hs || w_timeout) w_next = PKT;
        end else if (w_inject) begin
            if (axis_m.tready) w_next = DISCARD;
        end else if (w_hs && axis_s.tlast) begin
            w_next = IDLE;
        end
    end
    // The count only survives while the packet stays in PKT; any exit restarts it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= IDLE;
            r_beat_cnt     <= '0;
            r_pkt_tid      <= '0;
            r_pkt_tdest    <= '0;
            r_oversize_err <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_beat_cnt     <= (w_next == PKT) ? r_beat_cnt + BW'(w_hs) : '0;
            r_oversize_err <= w_force;
            if (r_state == IDLE && w_hs) begin
                r_pkt_tid   <= axis_s.tid;
                r_pkt_tdest <= axis_s.tdest;
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_egress_corrector.sv
// tb_axi_stream_egress_corrector: directed checks of pass-through, length capping, discard, reset and timeout injection.
module tb_axi_stream_egress_corrector;
    localparam int DW = 64, IDW = 4, DSW = 4, MAXB = 4, TO = 8;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic forced, ovf, tmo;
    int   errors = 0;
    int   checks = 0;
    axi_stream_egress_corrector_if #(.AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DSW)) s_if ();
    axi_stream_egress_corrector_if #(.AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DSW)) m_if ();
    axi_stream_egress_corrector #(
        .AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DSW),
        .MAX_PACKET_BEATS(MAXB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .axis_s(s_if.slave),
        .axis_m(m_if.master),
        .axis_tlast_forced(forced),
        .oversize_error(ovf),
        .timeout_error(tmo)
    );
    always #5 aclk = ~aclk;

    task automatic drive(input logic v, input logic l, input logic [DW-1:0] d, input logic [IDW-1:0] id);
        @(negedge aclk);
        s_if.tvalid = v;
        s_if.tlast  = l;
        s_if.tdata  = d;
        s_if.tid    = id;
        s_if.tdest  = ~id;
        s_if.tkeep  = 8'hff;
        #1;
    endtask

    task automatic test_reset();
        m_if.tready = 1'b1;
        aresetn = 1'b0;
        drive(1'b1, 1'b0, 64'h1, 4'h1);
        checks++;
        if ({m_if.tvalid, s_if.tready, forced, ovf, tmo} !== 5'b0) begin
            errors++;
            $display("FAIL reset: {mvalid,sready,forced,ovf,tmo} got %b want 00000", {m_if.tvalid, s_if.tready, forced, ovf, tmo});
        end
        drive(1'b0, 1'b0, 64'h0, 4'h0);
        aresetn = 1'b1;
    endtask

    task automatic test_legal(input int n);
        logic [DW-1:0] d;
        for (int i = 1; i <= n; i++) begin
            d = 64'hC0DE_0000_0000_0000 | 64'(i * 17 + n);
            drive(1'b1, i == n, d, 4'h2);
            checks++;
            if ({m_if.tvalid, m_if.tlast, forced, ovf, s_if.tready} !== {1'b1, i == n, 1'b0, 1'b0, 1'b1} || m_if.tdata !== d || m_if.tdest !== 4'hd) begin
                errors++;
                $display("FAIL legal%0d beat%0d: {v,last,forced,ovf,rdy} got %b want %b data got %h want %h",
                         n, i, {m_if.tvalid, m_if.tlast, forced, ovf, s_if.tready}, {1'b1, i == n, 3'b001}, m_if.tdata, d);
            end
        end
        drive(1'b0, 1'b0, 64'h0, 4'h0);
        checks++;
        if (ovf !== 1'b0 || m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL legal%0d tail: ovf got %b want 0 mvalid got %b want 0", n, ovf, m_if.tvalid);
        end
    endtask

    task automatic test_oversize();
        logic [DW-1:0] d;
        for (int i = 1; i <= 7; i++) begin
            d = 64'h0BAD_0000_0000_0000 | 64'(i);
            drive(1'b1, i == 7, d, 4'h6);
            checks++;
            if ({m_if.tvalid, m_if.tvalid & m_if.tlast, forced, ovf, s_if.tready} !== {i <= 4, i == 4, i == 4, i == 5, 1'b1}
                || (i <= 4 && m_if.tdata !== d)) begin
                errors++;
                $display("FAIL oversize beat%0d: {v,last,forced,ovf,rdy} got %b want %b",
                         i, {m_if.tvalid, m_if.tvalid & m_if.tlast, forced, ovf, s_if.tready}, {i <= 4, i == 4, i == 4, i == 5, 1'b1});
            end
        end
        drive(1'b0, 1'b0, 64'h0, 4'h0);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL oversize pulse width: ovf got %b want 0", ovf);
        end
        test_legal(1);
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 64'h11, 4'h3);
        m_if.tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 64'h22, 4'h3);
            checks++;
            if ({m_if.tvalid, s_if.tready, m_if.tlast, tmo, forced} !== 5'b10000 || m_if.tkeep !== 8'hff || m_if.tdata !== 64'h22) begin
                errors++;
                $display("FAIL stall cycle%0d: {v,rdy,last,tmo,forced} got %b want 10000 keep got %h want ff",
                         c, {m_if.tvalid, s_if.tready, m_if.tlast, tmo, forced}, m_if.tkeep);
            end
        end
        m_if.tready = 1'b1;
        drive(1'b1, 1'b0, 64'h22, 4'h3);
        drive(1'b1, 1'b0, 64'h33, 4'h3);
        checks++;
        if (forced !== 1'b0) begin
            errors++;
            $display("FAIL stall beat3: forced got %b want 0", forced);
        end
        drive(1'b1, 1'b0, 64'h44, 4'h3);
        checks++;
        if ({m_if.tvalid, m_if.tlast, forced} !== 3'b111) begin
            errors++;
            $display("FAIL stall beat4 force: {v,last,forced} got %b want 111", {m_if.tvalid, m_if.tlast, forced});
        end
        drive(1'b1, 1'b1, 64'h55, 4'h3);
        checks++;
        if ({m_if.tvalid, s_if.tready, ovf} !== 3'b011) begin
            errors++;
            $display("FAIL stall discard: {v,rdy,ovf} got %b want 011", {m_if.tvalid, s_if.tready, ovf});
        end
        drive(1'b0, 1'b0, 64'h0, 4'h0);
    endtask

`ifdef AXIS_TIMEOUT_INJECT_EN
    task automatic test_timeout();
        drive(1'b1, 1'b0, 64'hA1, 4'h3);
        drive(1'b1, 1'b0, 64'hA2, 4'h3);
        for (int k = 1; k <= TO + 1; k++) begin
            drive(1'b0, 1'b0, 64'hFF, 4'h0);
            checks++;
            if ({m_if.tvalid, tmo} !== 2'b00) begin
                errors++;
                $display("FAIL timeout idle%0d: {v,tmo} got %b want 00", k, {m_if.tvalid, tmo});
            end
        end
        drive(1'b0, 1'b0, 64'hFF, 4'h0);
        checks++;
        if ({m_if.tvalid, m_if.tlast, tmo, s_if.tready} !== 4'b1110 || m_if.tkeep !== 8'h00 || m_if.tdata !== 64'h0 || m_if.tid !== 4'h3 || m_if.tdest !== 4'hc) begin
            errors++;
            $display("FAIL inject beat: {v,last,tmo,rdy} got %b want 1110 keep %h tid %h tdest %h want 00/3/c",
                     {m_if.tvalid, m_if.tlast, tmo, s_if.tready}, m_if.tkeep, m_if.tid, m_if.tdest);
        end
        drive(1'b1, 1'b0, 64'hA3, 4'h3);
        checks++;
        if ({m_if.tvalid, s_if.tready, tmo} !== 3'b010) begin
            errors++;
            $display("FAIL inject discard: {v,rdy,tmo} got %b want 010", {m_if.tvalid, s_if.tready, tmo});
        end
        drive(1'b1, 1'b1, 64'hA4, 4'h3);
        checks++;
        if ({m_if.tvalid, s_if.tready, forced} !== 3'b010) begin
            errors++;
            $display("FAIL inject discard last: {v,rdy,forced} got %b want 010", {m_if.tvalid, s_if.tready, forced});
        end
        test_legal(2);
    endtask
`endif

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 64'h71, 4'h5);
        drive(1'b1, 1'b0, 64'h72, 4'h5);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid, s_if.tready, forced} !== 3'b000) begin
            errors++;
            $display("FAIL async reset: {v,rdy,forced} got %b want 000", {m_if.tvalid, s_if.tready, forced});
        end
        @(negedge aclk);
        aresetn = 1'b1;
        s_if.tvalid = 1'b0;
        test_legal(2);
        test_legal(4);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tkeep  = '0;
        m_if.tready = 1'b1;
        test_reset();
        test_legal(3);
        test_legal(4);
        test_oversize();
        test_backpressure();
`ifdef AXIS_TIMEOUT_INJECT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
